// File: rtl/seq_detect_sched_if.sv
// Requester-side bus of seq_detect_sched: requests, words, grants and job results.
interface seq_detect_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CNT_W   = 4
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      busy;
   logic                      done;
   logic [ID_W-1:0]           done_id;
   logic [CNT_W-1:0]          match_cnt;

   modport master (output req, req_data, input gnt, busy, done, done_id, match_cnt);
   modport slave  (input req, req_data, output gnt, busy, done, done_id, match_cnt);
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NUM_REQ word requesters.
// Optional macro SEQ_DETECT_SCHED_LSB_FIRST_EN: shift words LSB-first instead of MSB-first.
module seq_detect_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DRAIN   = 1,
   parameter int unsigned CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   seq_detect_sched_if.slave  bus,
   output logic               det_clr,
   output logic               det_din,
   input  logic               det_sout
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned DR_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SHIFT, ST_DRAIN, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d, cur_q, cur_d;
   logic [DATA_W-1:0]   sreg_q, sreg_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DR_W-1:0]     drn_q, drn_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic                busy_q, busy_d, clr_q, clr_d, din_q, din_d, done_q, done_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic [CNT_W-1:0]    mcnt_q, mcnt_d;

   logic [ID_W-1:0]     pick_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                shift_bit_c;
   logic [DATA_W-1:0]   sreg_next_c;

   // First set request at or after p, wrapping; lowest offset wins.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    p);
      logic [ID_W-1:0] pick;
      int              k;
      pick = p;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         k = (int'(p) + i) % int'(NUM_REQ);
         if (r[ID_W'(k)]) pick = ID_W'(k);
      end
      return pick;
   endfunction

   assign pick_c    = rr_pick(bus.req, ptr_q);
   assign cnt_inc_c = (det_sout && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef SEQ_DETECT_SCHED_LSB_FIRST_EN
   assign shift_bit_c = sreg_q[0];
   assign sreg_next_c = sreg_q >> 1;
`else
   assign shift_bit_c = sreg_q[DATA_W-1];
   assign sreg_next_c = sreg_q << 1;
`endif

   // Next-state and next-output logic; every output is the registered copy of a *_d value.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cur_d     = cur_q;
      sreg_d    = sreg_q;
      bit_d     = bit_q;
      drn_d     = drn_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      busy_d    = 1'b0;
      clr_d     = 1'b0;
      din_d     = 1'b0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      mcnt_d    = mcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               cur_d = pick_c;
               for (int i = 0; i < int'(NUM_REQ); i++) begin
                  if (pick_c == ID_W'(i)) sreg_d = bus.req_data[i*DATA_W +: DATA_W];
               end
               gnt_d   = NUM_REQ'(1) << pick_c;
               ptr_d   = (pick_c == ID_W'(NUM_REQ - 1)) ? '0 : pick_c + ID_W'(1);
               clr_d   = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            bit_d   = '0;
            drn_d   = '0;
            din_d   = shift_bit_c;
            sreg_d  = sreg_next_c;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_d = cnt_inc_c;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
               if (DRAIN == 0) begin
                  done_d    = 1'b1;
                  done_id_d = cur_q;
                  mcnt_d    = cnt_inc_c;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               bit_d  = bit_q + BIT_W'(1);
               din_d  = shift_bit_c;
               sreg_d = sreg_next_c;
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_inc_c;
            if (drn_q == DR_W'(DRAIN - 1)) begin
               done_d    = 1'b1;
               done_id_d = cur_q;
               mcnt_d    = cnt_inc_c;
               state_d   = ST_DONE;
            end else begin
               drn_d = drn_q + DR_W'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cur_q     <= '0;
         sreg_q    <= '0;
         bit_q     <= '0;
         drn_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         clr_q     <= 1'b0;
         din_q     <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         mcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cur_q     <= cur_d;
         sreg_q    <= sreg_d;
         bit_q     <= bit_d;
         drn_q     <= drn_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         clr_q     <= clr_d;
         din_q     <= din_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         mcnt_q    <= mcnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.match_cnt = mcnt_q;
   assign det_clr       = clr_q;
   assign det_din       = din_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed and random jobs against a job-level reference model.
// A second instance with CNT_W=3 shares the stimulus to cover counter saturation.
module tb_seq_detect_sched;
   logic clk = 1'b0;
   logic rst;
   logic det_clr, det_din, det_sout;
   logic det_clr3, det_din3;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_gnt = -100;
   int   ptr_m = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_detect_sched_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4)) bus ();
   seq_detect_sched_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(3)) bus3 ();

   assign bus3.req      = bus.req;
   assign bus3.req_data = bus.req_data;

   seq_detect_sched #(.NUM_REQ(4), .DATA_W(8), .DRAIN(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .det_clr(det_clr), .det_din(det_din), .det_sout(det_sout));

   seq_detect_sched #(.NUM_REQ(4), .DATA_W(8), .DRAIN(1), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3),
      .det_clr(det_clr3), .det_din(det_din3), .det_sout(det_sout));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first requester at or after the model pointer, wrapping.
   function automatic int model_pick(input logic [3:0] r);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (ptr_m + i) % 4;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      det_sout = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_clr", det_clr, 0);
      chk("rst_din", det_din, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_match_cnt", bus.match_cnt, 0);
      rst = 1'b0;
      ptr_m = 0;
      @(posedge clk);
      #1;
   endtask

   // One job from an idle scheduler. mask[0]=CLEAR, [1..8]=SHIFT, [9]=DRAIN, [10]=DONE cycle.
   task automatic run_job(input logic [3:0] reqv, input logic [31:0] words,
                          input logic [10:0] mask, input bit hold, input bit chk_gap);
      int         id;
      int         cnt;
      logic [7:0] w;
      logic       exp_bit;
      id  = model_pick(reqv);
      w   = words[id*8 +: 8];
      cnt = 0;
      for (int k = 1; k <= 9; k++) cnt += int'(mask[k]);
      ptr_m = (id + 1) % 4;
      bus.req      = reqv;
      bus.req_data = words;
      det_sout     = 1'b0;
      @(posedge clk);
      #1;
      chk("gnt", bus.gnt, 32'(4'b0001 << id));
      chk("clear_pulse", det_clr, 1);
      chk("clear_busy", bus.busy, 1);
      chk("clear_din", det_din, 0);
      if (chk_gap) chk("gnt_gap", cyc - last_gnt, 12);
      last_gnt = cyc;
      if (!hold) bus.req = reqv & ~(4'b0001 << id);
      bus.req_data = $urandom();
      det_sout = mask[0];
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
`ifdef SEQ_DETECT_SCHED_LSB_FIRST_EN
         exp_bit = w[k-1];
`else
         exp_bit = w[8-k];
`endif
         chk("shift_din", det_din, exp_bit);
         if (k == 1) chk("shift_clr_low", det_clr, 0);
         det_sout = mask[k];
      end
      @(posedge clk);
      #1;
      chk("drain_din", det_din, 0);
      chk("drain_no_done", bus.done, 0);
      det_sout = mask[9];
      @(posedge clk);
      #1;
      chk("done", bus.done, 1);
      chk("done_id", bus.done_id, id);
      chk("match_cnt", bus.match_cnt, (cnt > 15) ? 15 : cnt);
      chk("match_cnt_w3", bus3.match_cnt, (cnt > 7) ? 7 : cnt);
      det_sout = mask[10];
      @(posedge clk);
      #1;
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("held_match_cnt", bus.match_cnt, (cnt > 15) ? 15 : cnt);
      det_sout = 1'b0;
   endtask

   initial begin
      logic [3:0]  rv;
      logic [31:0] wv;
      logic [10:0] mv;

      do_reset();
      run_job(4'b0001, 32'h0000_00B4, 11'h000, 1'b0, 1'b0);
      run_job(4'b0001, 32'h0000_00B4, 11'h6A5, 1'b0, 1'b0);
      run_job(4'b0001, 32'h0000_00B4, 11'h3FE, 1'b0, 1'b0);

      // All requesters held: strict rotation, back-to-back grants.
      do_reset();
      for (int n = 0; n < 5; n++) begin
         wv = $urandom();
         mv = 11'($urandom());
         run_job(4'b1111, wv, mv, 1'b1, n > 0);
      end
      bus.req = '0;

      // Reset in the 4th SHIFT cycle of a requester-2 job.
      do_reset();
      bus.req = 4'b0100;
      bus.req_data = $urandom();
      @(posedge clk);
      #1;
      chk("abort_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ptr_m = 0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_din", det_din, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_match_cnt", bus.match_cnt, 0);
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", bus.done, 0);
      end
      run_job(4'b0110, $urandom(), 11'h000, 1'b0, 1'b0);

      // Random request patterns, words and detector pulses.
      for (int n = 0; n < 40; n++) begin
         rv = 4'($urandom_range(1, 15));
         wv = $urandom();
         mv = 11'($urandom());
         run_job(rv, wv, mv, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
